multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//   Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch/decode/execute/mem/writeback.
//   Drives datapath mux selects, write strobes and the 2-bit ALUOp consumed by the ALU decoder.
//   Sits upstream of the ALU decoder; its opcode input comes from the instruction register.
//   Also keeps a retired-instruction counter.
// PARAMETERS
//   CNT_W    32   width of retired-instruction counter instret
// PORTS
//   clk        in   1      rising-edge clock (single clock domain)
//   reset      in   1      asynchronous, active-high reset
//   opcode     in   7      instr[6:0] from IR; stable from DECODE until the next FETCH
//   zero       in   1      ALU zero flag
//   PCWrite    out  1      PC enable = PCUpdate | (Branch & zero)
//   AdrSrc     out  1      memory address: 0 = PC, 1 = Result
//   MemWrite   out  1      data memory write strobe
//   IRWrite    out  1      IR / OldPC load enable
//   RegWrite   out  1      register file write strobe
//   ResultSrc  out  2      00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA    out  2      00 = PC, 01 = OldPC, 10 = RD1
//   ALUSrcB    out  2      00 = RD2, 01 = ImmExt, 10 = const 4
//   ALUOp      out  2      00 = add, 01 = sub/branch, 10 = funct-decoded
//   illegal    out  1      illegal-opcode flag (see CONFIGURATION)
//   instret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//   Moore FSM. State register resets asynchronously to FETCH; outputs decode from state only.
//   Reset values: every output takes its FETCH value (below), illegal = 0, instret = 0.
//   Any output not listed for a state is 0 in that state.
//   Per-state outputs:
//     FETCH    IRWrite=1 AdrSrc=0 ALUSrcA=00 ALUSrcB=10 ALUOp=00 ResultSrc=10 PCUpdate=1
//     DECODE   ALUSrcA=01 ALUSrcB=01 ALUOp=00
//     MEMADR   ALUSrcA=10 ALUSrcB=01 ALUOp=00
//     MEMREAD  ResultSrc=00 AdrSrc=1
//     MEMWRITE ResultSrc=00 AdrSrc=1 MemWrite=1
//     MEMWB    ResultSrc=01 RegWrite=1
//     EXECR    ALUSrcA=10 ALUSrcB=00 ALUOp=10
//     EXECI    ALUSrcA=10 ALUSrcB=01 ALUOp=10
//     ALUWB    ResultSrc=00 RegWrite=1
//     BEQ      ALUSrcA=10 ALUSrcB=00 ALUOp=01 ResultSrc=00 Branch=1
//     JAL      ALUSrcA=01 ALUSrcB=10 ALUOp=00 ResultSrc=00 PCUpdate=1
//   Transitions:
//     FETCH -> DECODE, unconditional.
//     DECODE dispatches on opcode:
//       0000011 / 0100011 -> MEMADR    0110011 -> EXECR    0010011 -> EXECI
//       1101111 -> JAL                 1100011 -> BEQ      other -> see CONFIGURATION
//     MEMADR  -> MEMREAD if opcode = 0000011, else MEMWRITE.
//     MEMREAD -> MEMWB -> FETCH.    MEMWRITE -> FETCH.
//     EXECR / EXECI -> ALUWB -> FETCH.    JAL -> ALUWB.    BEQ -> FETCH.
//   Latency (cycles): lw 5, sw 4, R/I 4, jal 4, beq 3.
//   instret increments by 1 on the clock edge that leaves MEMWB, MEMWRITE, ALUWB or BEQ.
//   instret wraps modulo 2^CNT_W; no saturation.
//   Reset asserted mid-instruction: state -> FETCH and instret -> 0 immediately (async).
//     No strobe may remain asserted after reset assertion.
// CONFIGURATION
//   ILLEGAL_OP_EN defined: unknown opcode in DECODE -> HALT.
//     HALT: all strobes and selects 0, illegal = 1. HALT is left only by reset.
//   ILLEGAL_OP_EN undefined: unknown opcode in DECODE -> FETCH, treated as a NOP.
//     The NOP is not counted in instret. illegal is tied to 0; HALT state does not exist.
// STRUCTURE
//   Shared package riscv_ctrl_pkg holds:
//     state enum, opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ),
//     ResultSrc / ALUSrcA / ALUSrcB / ALUOp encodings.
//   One sub-module, ctrl_word_decode: combinational state -> control-word mapping.
//   Next-state logic, PCWrite gating and instret stay in this module.
// TESTING
//   Reset, then lw (0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
//     RegWrite=1 with ResultSrc=01 only in cycle 5; instret = 1.
//   sw (0100011) -> MemWrite=1 and AdrSrc=1 in cycle 4 only; RegWrite never asserted; instret +1.
//   beq with zero=1 -> PCWrite=1 in cycle 3.
//     Repeat with zero=0 -> PCWrite=0 in cycle 3. Both take 3 cycles.
//   R-type 0110011 -> ALUOp=10 with ALUSrcB=00 in EXECR.
//     I-type 0010011 -> ALUOp=10 with ALUSrcB=01 in EXECI. Then ALUWB.
//   Opcode 1111111:
//     macro on  -> HALT, illegal=1, held 10 cycles, strobes 0.
//     macro off -> back to FETCH, instret unchanged.
//   Preload instret = 2^CNT_W-1 (CNT_W=4: 15), retire one instruction -> instret = 0.
//     Assert reset during MEMREAD -> FETCH outputs and instret = 0 before the next edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: states, opcodes and datapath select encodings for the multicycle control FSM.
// HALT exists only when ILLEGAL_OP_EN is defined.
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
`ifdef ILLEGAL_OP_EN
    , S_HALT
`endif
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [1:0] RS_ALUOUT = 2'b00, RS_DATA = 2'b01, RS_ALURES = 2'b10;
  localparam logic [1:0] SA_PC = 2'b00, SA_OLDPC = 2'b01, SA_RD1 = 2'b10;
  localparam logic [1:0] SB_RD2 = 2'b00, SB_IMM = 2'b01, SB_FOUR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: IR/ALU flag inputs and datapath control outputs of the control FSM.
interface multicycle_ctrl_fsm_if #(parameter int CNT_W = 32);
  logic [6:0]       opcode;
  logic             zero;
  logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [CNT_W-1:0] instret;
  modport master(input opcode, zero,
                 output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal,
                        ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instret);
  modport slave(output opcode, zero,
                input PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal,
                      ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instret);
endinterface

// File: rtl/ctrl_word_decode.sv
// ctrl_word_decode: combinational state -> control word for the Moore control FSM.
module ctrl_word_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.pc_update  = 1'b1;
        ctrl_o.alu_src_a  = SA_PC;
        ctrl_o.alu_src_b  = SB_FOUR;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.result_src = RS_ALURES;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = SA_OLDPC;
        ctrl_o.alu_src_b = SB_IMM;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SA_RD1;
        ctrl_o.alu_src_b = SB_IMM;
      end
      S_MEMREAD: ctrl_o.adr_src = 1'b1;
      S_MEMWRITE: begin
        ctrl_o.adr_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RS_DATA;
        ctrl_o.reg_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a = SA_RD1;
        ctrl_o.alu_src_b = SB_RD2;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = SA_RD1;
        ctrl_o.alu_src_b = SB_IMM;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RS_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a = SA_RD1;
        ctrl_o.alu_src_b = SB_RD2;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.branch    = 1'b1;
      end
      S_JAL: begin
        ctrl_o.alu_src_a = SA_OLDPC;
        ctrl_o.alu_src_b = SB_FOUR;
        ctrl_o.pc_update = 1'b1;
      end
`ifdef ILLEGAL_OP_EN
      S_HALT: ctrl_o.illegal = 1'b1;
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: RV32I multicycle control FSM with retired-instruction counter.
// ILLEGAL_OP_EN: unknown opcodes halt the core (illegal=1) instead of acting as an uncounted NOP.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_fsm_if.master bus
);
`ifdef ILLEGAL_OP_EN
  localparam state_t S_BAD = S_HALT;
`else
  localparam state_t S_BAD = S_FETCH;
`endif
  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  ctrl_t            w;
  ctrl_word_decode u_dec (.state_i(state_q), .ctrl_o(w));
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                           (bus.opcode == OP_R)   ? S_EXECR :
                           (bus.opcode == OP_I)   ? S_EXECI :
                           (bus.opcode == OP_JAL) ? S_JAL   :
                           (bus.opcode == OP_BEQ) ? S_BEQ   : S_BAD;
      S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
      default:   state_d = state_q;
    endcase
  end
  assign retire = state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_q + CNT_W'(retire);
    end
  end
  assign bus.PCWrite   = w.pc_update | (w.branch & bus.zero);
  assign bus.AdrSrc    = w.adr_src;
  assign bus.MemWrite  = w.mem_write;
  assign bus.IRWrite   = w.ir_write;
  assign bus.RegWrite  = w.reg_write;
  assign bus.ResultSrc = w.result_src;
  assign bus.ALUSrcA   = w.alu_src_a;
  assign bus.ALUSrcB   = w.alu_src_b;
  assign bus.ALUOp     = w.alu_op;
  assign bus.illegal   = w.illegal;
  assign bus.instret   = instret_q;
endmodule
